// File: rtl/bus_pkg.sv
// Shared memory-bus definitions: arbiter FSM states, default timeout, and the
// command field encodings used by the bus, uart and arbiter blocks.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam logic [7:0] DEF_TIMEOUT = 8'd255;

  typedef enum logic [1:0] {
    BUS_CMD_NOP = 2'd0,
    BUS_CMD_RD  = 2'd1,
    BUS_CMD_WR  = 2'd2,
    BUS_CMD_RMW = 2'd3
  } bus_cmd_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set req bit at or above
// ptr wins, wrapping from N_REQ-1 back to 0.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  always_comb begin
    logic [IW:0] sum;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    sum    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // ptr < N_REQ and i < N_REQ, so one conditional subtract is a full modulo
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      if (!valid && req[sum[IW-1:0]]) begin
        valid               = 1'b1;
        idx                 = sum[IW-1:0];
        onehot[sum[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin memory bus arbiter: grants one requester, forwards its launch
// strobe, and waits for completion or timeout before re-arbitrating.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int         N_REQ   = 4,
  parameter logic [7:0] TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         start,
  input  logic                     bus_idle,
  input  logic                     fulfilled,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     bus_start,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t       state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    owner_nxt;
  logic [7:0]       cnt;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );

  assign owner_nxt = (owner == IW'(N_REQ-1)) ? '0 : owner + 1'b1;
  assign bus_start = (state == ST_GRANT) && start[owner];
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      owner       <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus_idle && pick_vld) begin
            grant <= pick_oh;
            owner <= pick_idx;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // a launch in the same cycle as req dropping still counts as a launch
          if (start[owner]) begin
            cnt   <= '0;
            state <= ST_WAIT;
          end else if (!req[owner]) begin
            grant  <= '0;
            rr_ptr <= owner_nxt;
            state  <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (fulfilled) begin
            grant <= '0;
            state <= ST_DONE;
          end else if (cnt == TIMEOUT) begin
            grant       <= '0;
            timeout_err <= 1'b1;
            state       <= ST_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_DONE: begin
          rr_ptr <= owner_nxt;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the memory bus (2..32).
REQ-002 Parameter TIMEOUT, default 255: max cycles from transaction launch to fulfilled, 8-bit.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 req  in  N_REQ  per-requester access request, level, held until served.
REQ-006 start  in  N_REQ  per-requester launch strobe; address/data/control are valid on the bus this cycle.
REQ-007 bus_idle  in  1  memory bus idle, ready to accept a command.
REQ-008 fulfilled  in  1  memory bus transaction complete, 1-cycle pulse.
REQ-009 grant  out  N_REQ  one-hot grant; at most one bit set.
REQ-010 owner  out  clog2(N_REQ)  index of current or last grantee.
REQ-011 bus_start  out  1  launch pulse forwarded to the memory bus.
REQ-012 busy  out  1  high in any state except IDLE.
REQ-013 timeout_err  out  1  1-cycle pulse when a transaction is abandoned on timeout.

Function
REQ-014 FSM states: IDLE, GRANT, WAIT, DONE; encoding 2 bits.
REQ-015 IDLE: if any req bit is set and bus_idle=1, pick the winner by round-robin from pointer rr_ptr, register grant and owner, go to GRANT; grant is visible 1 cycle after the qualifying req.
REQ-016 Round-robin: search from rr_ptr upward with wrap-around from N_REQ-1 to 0; the first set req bit wins.
REQ-017 GRANT: grant held; start[owner]=1 -> bus_start=1 the same cycle (combinational from registered owner), clear the timeout counter, go to WAIT.
REQ-018 GRANT: req[owner] drops before start -> drop grant, rr_ptr=owner+1 mod N_REQ, go to IDLE; no bus_start.
REQ-019 start bits from non-owners are ignored in every state; start[owner] outside GRANT is ignored.
REQ-020 WAIT: grant held; counter increments each cycle; fulfilled=1 -> DONE.
REQ-021 WAIT: counter reaches TIMEOUT without fulfilled -> timeout_err pulse 1 cycle, go to DONE.
REQ-022 Same cycle fulfilled and counter=TIMEOUT: fulfilled wins, no timeout_err.
REQ-023 DONE: grant all-zero, rr_ptr=owner+1 mod N_REQ, return to IDLE next cycle; bus turnaround is 1 cycle minimum.
REQ-024 The last granted requester shall have lowest priority in the next arbitration; with all req set, grants rotate 0,1,2,3,0...
REQ-025 fulfilled outside WAIT is ignored.
REQ-026 bus_idle=0 in IDLE shall block arbitration; bus_idle is not checked in other states.

Reset
REQ-027 rst=1 at a clock edge: state=IDLE, grant=0, owner=0, rr_ptr=0, counter=0, bus_start=0, busy=0, timeout_err=0.
REQ-028 rst asserted mid-transaction (GRANT/WAIT) shall abort with no DONE cycle and no timeout_err; the first arbitration after reset starts at requester 0.

Structure
REQ-029 Shared package bus_pkg holds: the FSM state typedef, the default TIMEOUT, and the bus control-field encodings shared with the bus and uart blocks.
REQ-030 One sub-module rr_pick: combinational round-robin priority encoder (req, rr_ptr -> one-hot + index, valid).
REQ-031 The arbiter drives only grant and bus_start; data/address muxing by grant is outside this block.

Verification
REQ-032 Reset, then req=0001, bus_idle=1 -> grant=0001 next cycle; start[0] -> bus_start pulse; fulfilled 3 cycles later -> DONE, grant=0, busy=0 one cycle later.
REQ-033 req=1111 held, each grantee starts and is fulfilled -> grant order 0001,0010,0100,1000,0001.
REQ-034 Grant 0010, start[1], no fulfilled for TIMEOUT=255 cycles -> timeout_err single pulse, grant=0, next winner index 2.
REQ-035 Grant 0100, start[0] and start[3] pulsed, then req[2] dropped -> no bus_start, IDLE, rr_ptr=3.
REQ-036 rst asserted in WAIT with req=1111 -> all outputs zero next cycle; after release, first grant=0001.
REQ-037 req=0001, bus_idle=0 for 10 cycles -> grant stays 0; bus_idle=1 -> grant=0001 next cycle.
